// File: rtl/kbd_playback_ctrl.sv
// Keyboard-driven playback controller: decodes ASCII commands, owns the sample
// address counter and issues one flash read per sample tick over req/ack.
module kbd_playback_ctrl #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 23'h7FFFF,
  parameter int unsigned STEP_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        key,
  input  logic              key_valid,
  input  logic              sample_tick,
  input  logic              read_ack,
  output logic              read_req,
  output logic [ADDR_W-1:0] addr,
  output logic              dir,
  output logic              playing,
  output logic [STEP_W-1:0] step,
  output logic              overrun
);

  typedef enum logic [1:0] {S_PAUSE, S_PLAY, S_FETCH} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_PAUSE, PEND_RESTART} pend_t;

  localparam logic [7:0] KEY_E     = 8'h45;
  localparam logic [7:0] KEY_D     = 8'h44;
  localparam logic [7:0] KEY_F     = 8'h46;
  localparam logic [7:0] KEY_B     = 8'h42;
  localparam logic [7:0] KEY_R     = 8'h52;
  localparam logic [7:0] KEY_PLUS  = 8'h2B;
  localparam logic [7:0] KEY_MINUS = 8'h2D;

  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W:0]   START_X  = (ADDR_W+1)'(START_ADDR);
  localparam logic [ADDR_W:0]   END_X    = (ADDR_W+1)'(END_ADDR);
  localparam logic [ADDR_W:0]   ONE_X    = (ADDR_W+1)'(1);
  localparam logic [STEP_W-1:0] STEP_MAX = '1;
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t              state_q, state_d;
  pend_t               pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ovr_q, ovr_d;

  logic                tick_from_play;
  logic                in_fetch;
  logic [ADDR_W:0]     addr_x, step_x, fwd_sum, fwd_x, bwd_x;
  logic [ADDR_W-1:0]   restart_addr, next_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PAUSE;
      pend_q  <= PEND_NONE;
      addr_q  <= START_A;
      dir_q   <= 1'b0;
      step_q  <= STEP_ONE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      ovr_q   <= ovr_d;
    end
  end

  // Wrap arithmetic in ADDR_W+1 bits so neither direction can overflow/underflow.
  always_comb begin
    addr_x  = {1'b0, addr_q};
    step_x  = (ADDR_W+1)'(step_d);
    fwd_sum = addr_x + step_x;
    fwd_x   = (fwd_sum > END_X) ? (START_X + (fwd_sum - END_X - ONE_X)) : fwd_sum;
    bwd_x   = (addr_x < (START_X + step_x)) ? (END_X + addr_x + ONE_X - START_X - step_x)
                                            : (addr_x - step_x);
    next_addr    = dir_d ? bwd_x[ADDR_W-1:0] : fwd_x[ADDR_W-1:0];
    restart_addr = dir_d ? END_A : START_A;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    step_d  = step_q;
    ovr_d   = ovr_q;

    // A tick out of PLAY enters FETCH; a key in that same cycle is handled as a FETCH key.
    tick_from_play = (state_q == S_PLAY) && sample_tick;
    in_fetch       = (state_q == S_FETCH) || tick_from_play;
    if (tick_from_play) state_d = S_FETCH;

    if (key_valid) begin
      case (key)
        KEY_F:     dir_d = 1'b0;
        KEY_B:     dir_d = 1'b1;
        KEY_PLUS:  if (step_q != STEP_MAX) step_d = step_q + STEP_ONE;
        KEY_MINUS: if (step_q != STEP_ONE) step_d = step_q - STEP_ONE;
        KEY_E:     if (state_q == S_PAUSE) state_d = S_PLAY;
        KEY_D: begin
          if (in_fetch)                pend_d  = PEND_PAUSE;
          else if (state_q == S_PLAY)  state_d = S_PAUSE;
        end
        KEY_R: begin
          ovr_d = 1'b0;
          if (in_fetch) pend_d = PEND_RESTART;
          else          addr_d = restart_addr;
        end
        default: ;
      endcase
    end

    if ((state_q == S_FETCH) && sample_tick) ovr_d = 1'b1;

    if ((state_q == S_FETCH) && read_ack) begin
      addr_d  = (pend_d == PEND_RESTART) ? restart_addr : next_addr;
      state_d = (pend_d == PEND_PAUSE) ? S_PAUSE : S_PLAY;
      pend_d  = PEND_NONE;
    end
  end

  assign read_req = (state_q == S_FETCH);
  assign playing  = (state_q != S_PAUSE);
  assign addr     = addr_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Scoreboard bench for kbd_playback_ctrl: directed scenarios plus random
// stimulus against a modular-arithmetic reference model.
module tb_kbd_playback_ctrl;

  localparam int ADDR_W   = 8;
  localparam int START_A  = 0;
  localparam int END_A    = 15;
  localparam int STEP_W   = 3;
  localparam int STEP_MAX = (1 << STEP_W) - 1;

  localparam logic [7:0] K_E = 8'h45, K_D = 8'h44, K_F = 8'h46, K_B = 8'h42,
                         K_R = 8'h52, K_P = 8'h2B, K_M = 8'h2D;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        key = '0;
  logic              key_valid = 1'b0;
  logic              sample_tick = 1'b0;
  logic              read_ack = 1'b0;
  logic              read_req;
  logic [ADDR_W-1:0] addr;
  logic              dir;
  logic              playing;
  logic [STEP_W-1:0] step;
  logic              overrun;

  kbd_playback_ctrl #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_A),
    .END_ADDR  (END_A),
    .STEP_W    (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_valid  (key_valid),
    .sample_tick(sample_tick),
    .read_ack   (read_ack),
    .read_req   (read_req),
    .addr       (addr),
    .dir        (dir),
    .playing    (playing),
    .step       (step),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rq;
    int addr;
    bit dir;
    bit play;
    int step;
    bit ovr;
  } snap_t;

  snap_t snap_q[$];
  int    fetch_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: m_play = PLAY or FETCH, m_busy = read outstanding.
  bit  m_play, m_busy, m_dir, m_ovr;
  int  m_addr, m_step;
  byte m_pend;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int restart_of(input bit d);
    return d ? END_A : START_A;
  endfunction

  function automatic int advance(input int a, input int s, input bit d);
    int range = END_A - START_A + 1;
    if (!d) return START_A + ((a - START_A + s) % range);
    return START_A + ((a - START_A - s + range) % range);
  endfunction

  task automatic model_step(input bit r, input bit kv, input logic [7:0] k,
                            input bit t, input bit a);
    bit was_fetch, was_play, fetch_now;
    if (r) begin
      m_play = 0; m_busy = 0; m_dir = 0; m_ovr = 0;
      m_addr = START_A; m_step = 1; m_pend = 0;
      return;
    end
    was_fetch = m_busy;
    was_play  = m_play && !m_busy;
    fetch_now = was_fetch || (was_play && t);
    if (was_play && t) begin
      m_busy = 1;
      fetch_q.push_back(m_addr);
    end
    if (kv) begin
      if (k == K_F) m_dir = 0;
      else if (k == K_B) m_dir = 1;
      else if (k == K_P) m_step = (m_step < STEP_MAX) ? m_step + 1 : STEP_MAX;
      else if (k == K_M) m_step = (m_step > 1) ? m_step - 1 : 1;
      else if (k == K_E) begin
        if (!m_play) m_play = 1;
      end else if (k == K_D) begin
        if (fetch_now) m_pend = "D";
        else if (was_play) m_play = 0;
      end else if (k == K_R) begin
        m_ovr = 0;
        if (fetch_now) m_pend = "R";
        else m_addr = restart_of(m_dir);
      end
    end
    if (was_fetch && t) m_ovr = 1;
    if (was_fetch && a) begin
      m_addr = (m_pend == "R") ? restart_of(m_dir) : advance(m_addr, m_step, m_dir);
      if (m_pend == "D") m_play = 0;
      m_busy = 0;
      m_pend = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit kv, input logic [7:0] k,
                     input bit t, input bit a);
    snap_t s;
    @(negedge clk);
    rst = r; key_valid = kv; key = k; sample_tick = t; read_ack = a;
    model_step(r, kv, k, t, a);
    s.rq = m_busy; s.addr = m_addr; s.dir = m_dir;
    s.play = m_play; s.step = m_step; s.ovr = m_ovr;
    snap_q.push_back(s);
  endtask

  task automatic idle();               cyc(0, 0, 8'h00, 0, 0); endtask
  task automatic press(input logic [7:0] k); cyc(0, 1, k, 0, 0); endtask
  task automatic tick();               cyc(0, 0, 8'h00, 1, 0); endtask
  task automatic ack();                cyc(0, 0, 8'h00, 0, 1); endtask
  task automatic fetch();              tick(); idle(); ack(); endtask
  task automatic settle();             @(posedge clk); #2; endtask

  // Monitor: per-cycle state comparison plus fetch-address check on each new request.
  initial begin
    snap_t e;
    bit prev_rq = 0;
    forever begin
      @(posedge clk); #1;
      if (snap_q.size() != 0) begin
        e = snap_q.pop_front();
        chk("read_req", int'(read_req), int'(e.rq));
        chk("addr",     int'(addr),     e.addr);
        chk("dir",      int'(dir),      int'(e.dir));
        chk("playing",  int'(playing),  int'(e.play));
        chk("step",     int'(step),     e.step);
        chk("overrun",  int'(overrun),  int'(e.ovr));
      end
      if (read_req && !prev_rq) begin
        if (fetch_q.size() == 0) chk("unexpected_read_req", 1, 0);
        else chk("fetch_addr", int'(addr), fetch_q.pop_front());
      end
      prev_rq = read_req;
    end
  end

  initial begin
    logic [7:0] keys [8];
    keys = '{K_E, K_D, K_F, K_B, K_R, K_P, K_M, 8'h41};

    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    idle();
    settle();
    chk("reset_addr", int'(addr), START_A);
    chk("reset_step", int'(step), 1);
    chk("reset_playing", int'(playing), 0);

    // Basic play: three acked fetches.
    press(K_E);
    repeat (3) begin fetch(); idle(); end
    settle();
    chk("play_addr3", int'(addr), 3);
    chk("play_playing", int'(playing), 1);

    // Forward wrap from 14 with step 3, then backward wrap.
    repeat (11) fetch();
    press(K_P); press(K_P);
    settle();
    chk("wrap_pre_addr", int'(addr), 14);
    fetch();
    settle();
    chk("fwd_wrap_addr", int'(addr), 1);
    press(K_B);
    fetch();
    settle();
    chk("bwd_wrap_addr", int'(addr), 14);

    // Pending D then R: R wins, keep playing at START_ADDR.
    press(K_F);
    tick(); press(K_D); press(K_R); ack();
    settle();
    chk("pend_r_addr", int'(addr), START_A);
    chk("pend_r_playing", int'(playing), 1);
    fetch(); fetch();
    // Pending R then D: D wins, pause with advanced address.
    tick(); press(K_R); press(K_D); ack();
    settle();
    chk("pend_d_playing", int'(playing), 0);
    chk("pend_d_addr", int'(addr), 9);

    // Overrun on tick during FETCH, cleared by R.
    press(K_E);
    tick(); tick(); idle(); ack();
    settle();
    chk("overrun_set", int'(overrun), 1);
    press(K_R);
    settle();
    chk("overrun_clr", int'(overrun), 0);

    // Step saturation.
    repeat (8) press(K_M);
    settle();
    chk("step_min", int'(step), 1);
    repeat (8) press(K_P);
    settle();
    chk("step_max", int'(step), STEP_MAX);

    // Reset mid-FETCH then a stray ack.
    tick(); idle();
    cyc(1, 0, 8'h00, 0, 0);
    ack();
    idle();
    settle();
    chk("rst_read_req", int'(read_req), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_addr", int'(addr), START_A);
    chk("rst_step", int'(step), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, kv, t, a;
      logic [7:0] k;
      r  = ($urandom_range(0, 299) == 0);
      kv = ($urandom_range(0, 3) == 0);
      k  = keys[$urandom_range(0, 7)];
      if (k == 8'h41) k = 8'($urandom);
      t  = ($urandom_range(0, 4) == 0);
      a  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      cyc(r, kv, k, t, a);
    end
    idle(); idle();
    settle();
    chk("fetch_queue_drained", fetch_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
